// File: rtl/srt_pkg.sv
// Shared scanout/RAM-arbiter definitions: bus widths, word/pixel types and
// the fetcher state encoding.
package srt_pkg;

  localparam int unsigned SRT_PIXEL_W = 16;
  localparam int unsigned SRT_WORD_W  = 32;
  localparam int unsigned SRT_ADDR_W  = 16;

  typedef logic [SRT_PIXEL_W-1:0] srt_pixel_t;
  typedef logic [SRT_WORD_W-1:0]  srt_word_t;
  typedef logic [SRT_ADDR_W-1:0]  srt_addr_t;

  typedef enum logic [1:0] {
    SF_IDLE,
    SF_FETCH,
    SF_DRAIN
  } sf_state_e;

  // Low pixel of a word is shown first.
  function automatic srt_pixel_t srt_unpack(input srt_word_t w, input logic hi);
    return hi ? w[SRT_WORD_W-1:SRT_PIXEL_W] : w[SRT_PIXEL_W-1:0];
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous word FIFO with a combinational head, occupancy count and a
// single-cycle flush that takes priority over push and pop.
module scanout_fifo
  import srt_pkg::*;
#(
  parameter int unsigned DEPTH = 128
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  srt_word_t              push_data,
  input  logic                   pop,
  output srt_word_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  srt_word_t     mem_q [DEPTH];
  logic          do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL) || do_pop);

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && !flush && do_push) mem_q[wr_q] <= push_data;
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/scanout_fetcher.sv
// Prefetches one display line of packed pixel words per lineRequest from RAM
// into a word FIFO and unpacks them into 16-bit pixels for the HDMI side.
module scanout_fetcher
  import srt_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 100,
  parameter int unsigned LINES          = 160,
  parameter srt_addr_t   BASE_ADDR      = 16'h0000,
  parameter int unsigned FIFO_DEPTH     = 128
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            frameStart,
  input  logic            lineRequest,
  output logic            ramEnable,
  output srt_addr_t       ramAddr,
  input  srt_word_t       ramData,
  input  logic            pixelReady,
  output srt_pixel_t      pixelData,
  output logic            pixelValid,
  output logic            underflow,
  output logic            lineOverrun
);

  localparam int unsigned IW = $clog2(WORDS_PER_LINE + 1);
  localparam int unsigned LW = $clog2(LINES + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] ISSUE_LAST = IW'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0] LINES_L    = LW'(LINES);
  localparam logic [CW:0]   DEPTH_L    = (CW+1)'(FIFO_DEPTH);

  sf_state_e       state_q, state_d;
  srt_addr_t       fetch_addr_q, fetch_addr_d;
  logic [IW-1:0]   issued_q, issued_d;
  logic [LW-1:0]   lines_q, lines_d;
  logic            half_q, half_d;
  logic            inflight_q, inflight_d;
  logic            underflow_q, underflow_d;
  logic            overrun_q, overrun_d;

  logic            issue, room, fire, pop;
  srt_word_t       fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;

  // The read in flight counts against capacity so its word always has a slot.
  assign room = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < DEPTH_L;
  assign fire = pixelReady && pixelValid;
  assign pop  = fire && half_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    issued_d     = issued_q;
    lines_d      = lines_q;
    half_d       = half_q;
    underflow_d  = underflow_q;
    overrun_d    = overrun_q;
    issue        = 1'b0;

    case (state_q)
      SF_IDLE: begin
        if (lineRequest && (lines_q < LINES_L)) begin
          state_d  = SF_FETCH;
          issued_d = '0;
        end
      end
      SF_FETCH: begin
        if (lineRequest) overrun_d = 1'b1;
        if (room) begin
          issue        = 1'b1;
          fetch_addr_d = fetch_addr_q + SRT_ADDR_W'(1);
          issued_d     = issued_q + IW'(1);
          if (issued_q == ISSUE_LAST) state_d = SF_DRAIN;
        end
      end
      SF_DRAIN: begin
        if (lineRequest) overrun_d = 1'b1;
        state_d = SF_IDLE;
        lines_d = lines_q + LW'(1);
      end
      default: state_d = SF_IDLE;
    endcase

    inflight_d = issue;

    if (fire) half_d = !half_q;
    if (pixelReady && !pixelValid) underflow_d = 1'b1;

    if (frameStart) begin
      state_d      = SF_IDLE;
      fetch_addr_d = BASE_ADDR;
      lines_d      = '0;
      half_d       = 1'b0;
      inflight_d   = 1'b0;
      underflow_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= SF_IDLE;
      fetch_addr_q <= BASE_ADDR;
      issued_q     <= '0;
      lines_q      <= '0;
      half_q       <= 1'b0;
      inflight_q   <= 1'b0;
      underflow_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      issued_q     <= issued_d;
      lines_q      <= lines_d;
      half_q       <= half_d;
      inflight_q   <= inflight_d;
      underflow_q  <= underflow_d;
      overrun_q    <= overrun_d;
    end
  end

  scanout_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (frameStart),
    .push      (inflight_q),
    .push_data (ramData),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Gated by reset_n so a reset mid-fetch issues nothing in the reset cycle.
  assign ramEnable   = issue && reset_n;
  assign ramAddr     = fetch_addr_q;
  assign pixelValid  = !fifo_empty;
  assign pixelData   = pixelValid ? srt_unpack(fifo_head, half_q) : '0;
  assign underflow   = underflow_q;
  assign lineOverrun = overrun_q;

endmodule

// File: tb/tb_scanout_fetcher.sv
// Randomised and directed bench for scanout_fetcher against a queue-based
// model of the line fetch and pixel stream.
module tb_scanout_fetcher;

  localparam int unsigned W     = 100;
  localparam int unsigned L     = 160;
  localparam int unsigned DEPTH = 128;
  localparam logic [15:0] BASE  = 16'hFFF0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frameStart = 1'b0;
  logic        lineRequest = 1'b0;
  logic        pixelReady = 1'b0;
  logic [31:0] ramData = '0;
  logic        ramEnable;
  logic [15:0] ramAddr;
  logic [15:0] pixelData;
  logic        pixelValid, underflow, lineOverrun;

  always #5 clock = ~clock;

  scanout_fetcher #(
    .WORDS_PER_LINE(W),
    .LINES         (L),
    .BASE_ADDR     (BASE),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frameStart  (frameStart),
    .lineRequest (lineRequest),
    .ramEnable   (ramEnable),
    .ramAddr     (ramAddr),
    .ramData     (ramData),
    .pixelReady  (pixelReady),
    .pixelData   (pixelData),
    .pixelValid  (pixelValid),
    .underflow   (underflow),
    .lineOverrun (lineOverrun)
  );

  // Word i of the frame holds pixels A000+i (first) and B000+i (second).
  function automatic logic [31:0] ramword(input logic [15:0] a);
    logic [15:0] i;
    i = a - BASE;
    return {16'hB000 + i, 16'hA000 + i};
  endfunction

  always @(posedge clock) ramData <= (ramEnable === 1'b1) ? ramword(ramAddr) : $urandom;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
  endtask

  // Behavioural model
  logic [31:0] m_q[$];
  bit          m_fetch, m_drain, m_half, m_uf, m_ov, m_infl;
  int          m_issued, m_lines;
  logic [15:0] m_addr;
  logic [31:0] m_infl_word;
  bit          u_en, u_fetch, u_drain;

  function automatic logic m_en();
    return reset_n && m_fetch && !m_drain && ((m_q.size() + (m_infl ? 1 : 0)) < DEPTH);
  endfunction

  function automatic logic [15:0] m_pix();
    if (m_q.size() == 0) return 16'h0000;
    return m_half ? m_q[0][31:16] : m_q[0][15:0];
  endfunction

  always @(posedge clock) begin
    u_en    = m_en();
    u_fetch = m_fetch;
    u_drain = m_drain;
    if (!reset_n || frameStart) begin
      m_fetch = 0; m_drain = 0; m_issued = 0; m_addr = BASE; m_q.delete();
      m_half = 0; m_uf = 0; m_ov = 0; m_lines = 0; m_infl = 0;
    end else begin
      if (pixelReady) begin
        if (m_q.size() > 0) begin
          if (m_half) void'(m_q.pop_front());
          m_half = !m_half;
        end else m_uf = 1;
      end
      if (m_infl) m_q.push_back(m_infl_word);
      m_infl = u_en;
      if (u_en) begin
        m_infl_word = ramword(m_addr);
        m_addr = m_addr + 16'd1;
        m_issued++;
      end
      if (u_fetch) begin
        if (lineRequest) m_ov = 1;
        if (u_drain) begin
          m_fetch = 0; m_drain = 0; m_lines++;
        end else if (m_issued == W) m_drain = 1;
      end else if (lineRequest && m_lines < L) begin
        m_fetch = 1; m_issued = 0;
      end
    end
  end

  bit          chk_on = 0;
  int          en_cnt = 0;
  logic [15:0] en_addrs[$];
  logic [15:0] px_log[$];

  always @(negedge clock) begin
    if (chk_on) begin
      chk("ramEnable", ramEnable, m_en());
      chk("ramAddr", ramAddr, m_addr);
      chk("pixelValid", pixelValid, m_q.size() != 0);
      chk("pixelData", pixelData, m_pix());
      chk("underflow", underflow, m_uf);
      chk("lineOverrun", lineOverrun, m_ov);
      if (ramEnable === 1'b1) begin
        en_cnt++;
        en_addrs.push_back(ramAddr);
      end
      if (pixelReady && pixelValid === 1'b1) px_log.push_back(pixelData);
    end
  end

  task automatic tick(input logic fs, input logic lr, input logic pr);
    frameStart = fs; lineRequest = lr; pixelReady = pr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic pr);
    repeat (n) tick(1'b0, 1'b0, pr);
  endtask

  task automatic wait_idle(input string name, input int budget, input logic pr);
    int c = 0;
    while (m_fetch && c < budget) begin tick(1'b0, 1'b0, pr); c++; end
    chk(name, m_fetch, 1'b0);
  endtask

  task automatic drain_all(input string name, input int budget);
    int c = 0;
    while ((m_fetch || m_infl || m_q.size() != 0) && c < budget) begin
      tick(1'b0, 1'b0, 1'b1); c++;
    end
    chk(name, pixelValid, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    tick(0, 0, 0);
    chk_on = 1;
    idle(2, 0);
    chk("rst_ramAddr", ramAddr, BASE);
    chk("rst_ramEnable", ramEnable, 1'b0);
    chk("rst_pixelValid", pixelValid, 1'b0);
    chk("rst_pixelData", pixelData, 16'h0000);
    chk("rst_underflow", underflow, 1'b0);
    reset_n = 1'b1;

    // First line: latency, length, addresses including wrap
    tick(1, 0, 0);
    en_cnt = 0; en_addrs.delete();
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("pv_after_1", pixelValid, 1'b0);
    tick(0, 0, 0);
    chk("pv_after_2", pixelValid, 1'b1);
    chk("first_pixel", pixelData, 16'hA000);
    idle(105, 0);
    chk("line_reads", en_cnt, 100);
    chk("first_addr", en_addrs[0], 16'hFFF0);
    chk("wrap_prev", en_addrs[15], 16'hFFFF);
    chk("wrap_addr", en_addrs[16], 16'h0000);
    chk("last_addr", en_addrs[99], 16'h0053);

    // Drain 200 pixels
    px_log.delete();
    idle(200, 1);
    chk("px_count", px_log.size(), 200);
    chk("px0", px_log[0], 16'hA000);
    chk("px1", px_log[1], 16'hB000);
    chk("px2", px_log[2], 16'hA001);
    chk("px3", px_log[3], 16'hB001);
    chk("px_last", px_log[199], 16'hB063);
    chk("px_empty", pixelValid, 1'b0);

    // Backpressure: second line stalls at FIFO capacity
    tick(0, 1, 0);
    wait_idle("line2_done", 300, 0);
    en_cnt = 0;
    tick(0, 1, 0);
    idle(150, 0);
    chk("stall_reads", en_cnt, 28);
    chk("stall_en", ramEnable, 1'b0);
    px_log.delete();
    drain_all("stall_drain", 2000);
    chk("stall_total_reads", en_cnt, 100);
    chk("stall_px_count", px_log.size(), 400);
    for (int i = 0; i < 400; i++)
      chk("stall_px_seq", px_log[i], ((i % 2) ? 16'hB000 : 16'hA000) + 16'(100 + i / 2));

    // Overrun
    tick(1, 0, 0);
    en_cnt = 0;
    tick(0, 1, 0);
    idle(9, 0);
    tick(0, 1, 0);
    chk("overrun_set", lineOverrun, 1'b1);
    wait_idle("overrun_done", 300, 0);
    chk("overrun_reads", en_cnt, 100);
    chk("overrun_hold", lineOverrun, 1'b1);
    tick(1, 0, 0);
    chk("overrun_clr", lineOverrun, 1'b0);
    chk("fs_addr", ramAddr, BASE);
    chk("fs_flush", pixelValid, 1'b0);

    // Underflow
    tick(0, 0, 1);
    chk("underflow_set", underflow, 1'b1);
    idle(5, 0);
    chk("underflow_hold", underflow, 1'b1);
    tick(1, 0, 0);
    chk("underflow_clr", underflow, 1'b0);

    // Reset in the middle of a fetch
    tick(0, 1, 0);
    idle(20, 0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_en", ramEnable, 1'b0);
    tick(0, 0, 0);
    reset_n = 1'b1;
    en_cnt = 0;
    idle(5, 0);
    chk("rst_mid_noreads", en_cnt, 0);
    chk("rst_mid_empty", pixelValid, 1'b0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(1499, 0) == 0) begin
        reset_n = 1'b0;
        tick(0, 0, 0);
        reset_n = 1'b1;
      end else begin
        tick($urandom_range(399, 0) == 0, $urandom_range(59, 0) == 0, $urandom_range(2, 0) != 0);
      end
    end

    // Line limit per frame
    tick(1, 0, 0);
    for (int n = 0; n < L; n++) begin
      tick(0, 1, 1);
      wait_idle("frame_line", 400, 1);
    end
    en_cnt = 0;
    tick(0, 1, 1);
    idle(10, 1);
    chk("line161_reads", en_cnt, 0);
    tick(1, 0, 0);
    en_cnt = 0; en_addrs.delete();
    tick(0, 1, 0);
    idle(3, 0);
    chk("restart_addr", en_addrs[0], 16'hFFF0);
    chk("restart_reads", en_cnt, 3);
    idle(110, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
